// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, parameter defaults and an address legality helper.
package dmem_pkg;

    localparam int WORD_W          = 32;
    localparam int BYTE_W          = 8;
    localparam int BE_W            = WORD_W / BYTE_W;
    localparam int ADDR_W          = 32;
    localparam int CNT_W           = 4;
    localparam int DEPTH_DEFAULT   = 64;
    localparam int LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word-aligned and inside the array; anything else is answered with an error.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr, input int depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[ADDR_W-1:2]} < ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a core (master) and the data-memory responder (slave).
// One outstanding transaction at a time; valid/ready handshake on both channels.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_be_merge.sv
// Combinational byte-enable merge: each enabled byte takes wdata, the rest keep the old word.
module dmem_be_merge
    import dmem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] new_word
);

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_byte
            assign new_word[gi*BYTE_W +: BYTE_W] = be[gi] ? wdata[gi*BYTE_W +: BYTE_W]
                                                          : old_word[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Memory is cleared on reset, so it is built from registers rather than block RAM.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit ZERO_LAT = (LATENCY == 0);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ready_reg;
    logic              valid_reg;
    logic              err_reg;
    logic [WORD_W-1:0] rdata_reg;

    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic [BE_W-1:0]   be_reg;

    logic [WORD_W-1:0] mem_reg [DEPTH];

    logic              accept;
    logic              acc_fire;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_ok;
    logic [IDX_W-1:0]  acc_idx;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged_word;
    logic [WORD_W-1:0] acc_rdata;
    logic [DEPTH-1:0]  word_we;

    assign accept = ready_reg && bus.req_valid;

    // With zero latency the access happens on the acceptance edge, so it uses the live request.
    always_comb begin
        acc_we    = we_reg;
        acc_addr  = addr_reg;
        acc_wdata = wdata_reg;
        acc_be    = be_reg;
        acc_fire  = (state_reg == WAIT) && (cnt_reg == '0);
        if (ZERO_LAT) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
            acc_fire  = accept;
        end
    end

    assign acc_ok    = addr_legal(acc_addr, DEPTH);
    assign acc_idx   = acc_addr[IDX_W+1:2];
    assign old_word  = mem_reg[acc_idx];
    assign acc_rdata = (acc_ok && !acc_we) ? old_word : '0;

    dmem_be_merge u_merge (
        .old_word (old_word),
        .wdata    (acc_wdata),
        .be       (acc_be),
        .new_word (merged_word)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
            assign word_we[gi] = acc_fire && acc_we && acc_ok && (acc_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_reg[i] <= '0;
            end else if (word_we[i]) begin
                mem_reg[i] <= merged_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg    <= bus.req_we;
                        addr_reg  <= bus.req_addr;
                        wdata_reg <= bus.req_wdata;
                        be_reg    <= bus.req_be;
                        ready_reg <= 1'b0;
                        if (ZERO_LAT) begin
                            state_reg <= RESP;
                            valid_reg <= 1'b1;
                            rdata_reg <= acc_rdata;
                            err_reg   <= !acc_ok;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                        valid_reg <= 1'b1;
                        rdata_reg <= acc_rdata;
                        err_reg   <= !acc_ok;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    // Completion edge only returns to IDLE; a new request waits one more cycle.
                    if (bus.rsp_ready) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_reg;
    assign bus.rsp_valid = valid_reg;
    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=64, LATENCY=2): loads, stores, errors,
// backpressure and reset mid-transaction, each checked against hand-computed values.
module tb_dmem_responder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dmem_if bus ();

    dmem_responder #(
        .DEPTH   (64),
        .LATENCY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and return at the negedge of the first rsp_valid cycle.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
        int guard;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
    endtask

    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        xact(we, addr, wdata, be, rdata, err, lat);
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        $display("xact %s we=%0b addr=%h wdata=%h be=%h -> rdata=%h err=%0b lat=%0d",
                 tag, we, addr, wdata, be, rdata, err, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        seen_valid;

        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0000_0000);
        check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        $display("reset: req_ready=%0b rsp_valid=%0b", bus.req_ready, bus.rsp_valid);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run("ld10",      1'b0, 32'h10,  32'h0,         4'h0, 32'h0000_0000, 1'b0);
        run("st08_full", 1'b1, 32'h08,  32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0);
        run("ld08_full", 1'b0, 32'h08,  32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0);
        run("st08_part", 1'b1, 32'h08,  32'h0000_1234, 4'h3, 32'h0000_0000, 1'b0);
        run("ld08_part", 1'b0, 32'h08,  32'h0,         4'h0, 32'hDEAD_1234, 1'b0);
        run("st08_be0",  1'b1, 32'h08,  32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0);
        run("ld08_be0",  1'b0, 32'h08,  32'h0,         4'h0, 32'hDEAD_1234, 1'b0);
        run("ld0a_mis",  1'b0, 32'h0A,  32'h0,         4'h0, 32'h0000_0000, 1'b1);
        run("st100_oor", 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1);
        run("ld00",      1'b0, 32'h00,  32'h0,         4'h0, 32'h0000_0000, 1'b0);

        // Backpressure: response must hold while rsp_ready stays low.
        bus.rsp_ready = 1'b0;
        xact(1'b0, 32'h08, 32'h0, 4'h0, rdata, err, lat);
        check("bp_lat",   32'(lat), 32'd3);
        check("bp_rdata", rdata, 32'hDEAD_1234);
        $display("xact bp_ld08 addr=%h -> rdata=%h err=%0b lat=%0d", 32'h08, rdata, err, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_hold_rdata", bus.rsp_rdata, 32'hDEAD_1234);
            check("bp_hold_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_done_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("bp_done_ready", {31'd0, bus.req_ready}, 32'd1);
        $display("xact bp_release -> rsp_valid=%0b req_ready=%0b", bus.rsp_valid, bus.req_ready);
        @(posedge clk);
        #1;

        // Reset while a store sits in WAIT: the store must never land.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h04;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_be    = 4'hF;
        @(negedge clk);
        check("rm_accept_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen_valid = 1'b1;
        end
        check("rm_no_rsp", {31'd0, seen_valid}, 32'd0);
        check("rm_ready",  {31'd0, bus.req_ready}, 32'd1);
        $display("xact rst_mid_st04 -> rsp_seen=%0b", seen_valid);
        @(posedge clk);
        #1;
        run("ld04_after_rst", 1'b0, 32'h04, 32'h0, 4'h0, 32'h0000_0000, 1'b0);
        run("ld08_after_rst", 1'b0, 32'h08, 32'h0, 4'h0, 32'h0000_0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (range 0..15).
REQ-003 The block SHALL have the port clk, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port reset, input, width 1, a synchronous, active-high reset.
REQ-005 The block SHALL have the port req_valid, input, width 1, meaning the core presents a request.
REQ-006 The block SHALL have the port req_ready, output, width 1, meaning the responder accepts a request this cycle.
REQ-007 The block SHALL have the port req_we, input, width 1: 1 = store, 0 = load.
REQ-008 The block SHALL have the port req_addr, input, width 32, a byte address.
REQ-009 The block SHALL have the port req_wdata, input, width 32, the store data.
REQ-010 The block SHALL have the port req_be, input, width 4, the store byte enables; bit n enables byte n, i.e. bits [8n+7:8n].
REQ-011 The block SHALL have the port rsp_valid, output, width 1, meaning a response is presented.
REQ-012 The block SHALL have the port rsp_ready, input, width 1, meaning the core accepts the response.
REQ-013 The block SHALL have the port rsp_rdata, output, width 32, the load data (0 for stores and errors).
REQ-014 The block SHALL have the port rsp_err, output, width 1, meaning the request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017 A request SHALL be accepted when req_valid && req_ready at a clock edge; we, addr, wdata and be are captured, and request inputs are ignored at all other times.
REQ-018 On acceptance, if LATENCY > 0 the FSM SHALL go to WAIT with the counter loaded to LATENCY-1; if LATENCY == 0 it SHALL perform the access and go directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at count 0 the access is performed and the FSM goes to RESP.
REQ-020 Latency SHALL be LATENCY+1 cycles from the acceptance edge to the first rsp_valid=1 cycle.
REQ-021 The access SHALL be error-free when addr[1:0] == 0 and addr[31:2] < DEPTH; otherwise rsp_err=1, rsp_rdata=0, and memory is unchanged.
REQ-022 A load SHALL register mem[addr[31:2]] into rsp_rdata with rsp_err=0.
REQ-023 A store SHALL update only the enabled bytes of mem[addr[31:2]] with rsp_rdata=0.
REQ-024 A store with be=4'b0000 SHALL be a legal no-op that still produces a response with err=0.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1; on that edge the FSM returns to IDLE.
REQ-026 A new request SHALL NOT be accepted on the same edge a response completes, so the minimum request-to-request spacing is LATENCY+2 cycles.
REQ-027 A store followed by a load to the same word SHALL return the merged store data (read-after-write ordering guaranteed by single outstanding transaction).
REQ-028 A load occurring while rsp_ready is stuck low SHALL stall indefinitely in RESP with no data change.

Reset
REQ-029 While reset=1, the FSM SHALL be in IDLE, the counter 0, req_ready=1 from the first post-reset cycle, rsp_valid=0, rsp_rdata=0, and rsp_err=0.
REQ-030 Reset SHALL clear all DEPTH memory words to 32'h00000000.
REQ-031 Reset during WAIT or RESP SHALL abort the transaction: no response is issued, and a store not yet performed SHALL be discarded.
REQ-032 Reset SHALL take priority over every other event on the same edge.

Structure
REQ-033 The shared package dmem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the DEPTH and LATENCY defaults, and the word/byte width constants.
REQ-034 The byte-enable merge SHALL be one combinational sub-module dmem_be_merge (old word, wdata, be -> new word).
REQ-035 The FSM, counter and storage array SHALL remain in dmem_responder.

Verification
REQ-036 The bench SHALL cover reset then load: after reset, load addr 0x10 with rsp_ready=1 -> rsp_valid at cycle 3 after acceptance (LATENCY=2), rdata=0x00000000, err=0.
REQ-037 The bench SHALL cover a full-word store then load: store 0xDEADBEEF, be=4'hF to addr 0x08, then load 0x08 -> rdata=0xDEADBEEF, err=0.
REQ-038 The bench SHALL cover a partial store: after the previous scenario, store 0x00001234, be=4'b0011 to 0x08, then load -> rdata=0xDEAD1234.
REQ-039 The bench SHALL cover errors: load addr 0x0A (misaligned) -> err=1, rdata=0; store to addr 0x100 (word 64, DEPTH=64) -> err=1, and a later load of 0x00 still returns 0.
REQ-040 The bench SHALL cover backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0 throughout; accepted on the 6th cycle, then IDLE.
REQ-041 The bench SHALL cover reset mid-operation: assert reset during WAIT of a store of 0xFFFFFFFF to 0x04 -> no rsp_valid; a later load of 0x04 returns 0x00000000.
